uart_ram_sequencer: RTL and testbench

- Sequencer on the UART side of the RAM port mux; owns the mux select line.
- Phase 1: writes a streamed input image from UART RX sequentially into RAM.
- Phase 2: hands RAM to the downsampling processor and waits for it to finish.
- Phase 3: reclaims RAM and streams the downsampled result back out through UART TX.

---
 rtl/uart_ram_sequencer.sv | 171 +++++++++++++++++
 tb/tb_uart_ram_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ram_sequencer.sv
// uart_ram_sequencer
//   UART-side sequencer for the shared image RAM. Loads an image streamed in
//   over UART RX, hands the RAM to the downsampling processor, then reads the
//   result back and streams it out over UART TX. Owns the RAM mux select.
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   rx_data, rx_valid     received UART byte and its one-cycle strobe
//   proc_done             processor finished (level or pulse)
//   tx_busy               UART TX busy, rises the cycle after tx_start
//   ram_q                 RAM read data, one cycle after the address
//   ram_addr, ram_wdata   UART-side RAM address / write data
//   ram_wr_en             UART-side RAM write enable
//   select                mux select: 0 = UART side, 1 = processor
//   proc_start            one-cycle processor start pulse
//   tx_data, tx_start     byte to transmit and its one-cycle start pulse
//   done                  dump complete, held until reset
//
// state  | meaning
// S_LOAD | write each received byte to RAM at index
// S_PROC | RAM handed to processor; wait for proc_done
// S_RD   | present DUMP_BASE+index to RAM
// S_RDW  | RAM read latency
// S_TX   | wait for TX idle, launch byte
// S_TXG  | guard cycle while tx_busy rises
// S_TXW  | wait for TX idle, advance index
// S_DONE | dump finished, idle until reset

module uart_ram_sequencer #(
    parameter int unsigned LOAD_BYTES = 65536,
    parameter int unsigned DUMP_BYTES = 16384,
    parameter logic [15:0] DUMP_BASE  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        proc_done,
    input  logic        tx_busy,
    input  logic [7:0]  ram_q,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_wr_en,
    output logic        select,
    output logic        proc_start,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        done
);

    typedef enum logic [2:0] {
        S_LOAD, S_PROC, S_RD, S_RDW, S_TX, S_TXG, S_TXW, S_DONE
    } state_t;

    localparam logic [16:0] LOAD_LAST = 17'(LOAD_BYTES - 1);
    localparam logic [16:0] DUMP_END  = 17'(DUMP_BYTES);

    state_t      state, state_nxt;
    logic [16:0] index, index_nxt, index_inc;
    logic [15:0] ram_addr_nxt;
    logic [7:0]  ram_wdata_nxt, tx_data_nxt;
    logic        ram_wr_en_nxt, select_nxt, proc_start_nxt, tx_start_nxt, done_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_LOAD;
            index      <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_wr_en  <= 1'b0;
            select     <= 1'b0;
            proc_start <= 1'b0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            index      <= index_nxt;
            ram_addr   <= ram_addr_nxt;
            ram_wdata  <= ram_wdata_nxt;
            ram_wr_en  <= ram_wr_en_nxt;
            select     <= select_nxt;
            proc_start <= proc_start_nxt;
            tx_data    <= tx_data_nxt;
            tx_start   <= tx_start_nxt;
            done       <= done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        index_nxt      = index;
        index_inc      = index + 17'd1;
        ram_addr_nxt   = ram_addr;
        ram_wdata_nxt  = ram_wdata;
        ram_wr_en_nxt  = 1'b0;
        select_nxt     = select;
        proc_start_nxt = 1'b0;
        tx_data_nxt    = tx_data;
        tx_start_nxt   = 1'b0;
        done_nxt       = done;

        case (state)
            S_LOAD: begin
                if (rx_valid) begin
                    ram_wr_en_nxt = 1'b1;
                    ram_addr_nxt  = index[15:0];
                    ram_wdata_nxt = rx_data;
                    if (index == LOAD_LAST) begin
                        index_nxt = '0;
                        state_nxt = S_PROC;
                    end else begin
                        index_nxt = index_inc;
                    end
                end
            end
            S_PROC: begin
                // The first cycle here carries the final load write, so the
                // handoff waits one cycle and select low doubles as the
                // "entry not yet done" marker. proc_done is honoured only
                // once the processor has actually been started.
                if (!select) begin
                    select_nxt     = 1'b1;
                    proc_start_nxt = 1'b1;
                end else if (proc_done) begin
                    select_nxt   = 1'b0;
                    ram_addr_nxt = DUMP_BASE + index[15:0];
                    state_nxt    = S_RD;
                end
            end
            S_RD: begin
                ram_addr_nxt = DUMP_BASE + index[15:0];
                state_nxt    = S_RDW;
            end
            S_RDW: begin
                state_nxt = S_TX;
            end
            S_TX: begin
                if (!tx_busy) begin
                    tx_data_nxt  = ram_q;
                    tx_start_nxt = 1'b1;
                    state_nxt    = S_TXG;
                end
            end
            S_TXG: begin
                state_nxt = S_TXW;
            end
            S_TXW: begin
                if (!tx_busy) begin
                    index_nxt = index_inc;
                    if (index_inc == DUMP_END) begin
                        done_nxt   = 1'b1;
                        select_nxt = 1'b0;
                        state_nxt  = S_DONE;
                    end else begin
                        ram_addr_nxt = DUMP_BASE + index_inc[15:0];
                        state_nxt    = S_RD;
                    end
                end
            end
            S_DONE: begin
                done_nxt   = 1'b1;
                select_nxt = 1'b0;
            end
            default: begin
                state_nxt = S_LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_ram_sequencer.sv
// Testbench for uart_ram_sequencer: a small instance (4-byte load, 2-byte dump
// at 0x0010) driven against RAM / TX / processor models, plus a full-size
// load instance for the 16-bit address wrap.

module tb_uart_ram_sequencer;

    localparam logic [15:0] BASE   = 16'h0010;
    localparam int          NLOAD  = 4;
    localparam int          NDUMP  = 2;
    localparam int          TXBUSY = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        proc_done = 1'b0;
    logic        tx_busy;
    logic [7:0]  ram_q;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_wr_en, select, proc_start, tx_start, done;
    logic [7:0]  tx_data;

    uart_ram_sequencer #(.LOAD_BYTES(NLOAD), .DUMP_BYTES(NDUMP), .DUMP_BASE(BASE)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .proc_done(proc_done), .tx_busy(tx_busy), .ram_q(ram_q),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wr_en(ram_wr_en),
        .select(select), .proc_start(proc_start), .tx_data(tx_data),
        .tx_start(tx_start), .done(done)
    );

    logic        w_rst = 1'b1;
    logic [7:0]  w_rx_data = 8'h00;
    logic        w_rx_valid = 1'b0;
    logic        w_proc_done = 1'b0;
    logic        w_tx_busy = 1'b0;
    logic [7:0]  w_ram_q = 8'h00;
    logic [15:0] w_ram_addr;
    logic [7:0]  w_ram_wdata, w_tx_data;
    logic        w_ram_wr_en, w_select, w_proc_start, w_tx_start, w_done;

    uart_ram_sequencer #(.LOAD_BYTES(65536), .DUMP_BYTES(1), .DUMP_BASE(16'h0000)) dut_wrap (
        .clk(clk), .rst(w_rst), .rx_data(w_rx_data), .rx_valid(w_rx_valid),
        .proc_done(w_proc_done), .tx_busy(w_tx_busy), .ram_q(w_ram_q),
        .ram_addr(w_ram_addr), .ram_wdata(w_ram_wdata), .ram_wr_en(w_ram_wr_en),
        .select(w_select), .proc_start(w_proc_start), .tx_data(w_tx_data),
        .tx_start(w_tx_start), .done(w_done)
    );

    int checks = 0;
    int errors = 0;

    // RAM model: UART-side writes land only while the UART side owns the mux.
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (ram_wr_en && !select) mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    // UART TX model: busy for TXBUSY cycles starting the cycle after tx_start.
    int tx_cnt = 0;
    assign tx_busy = (tx_cnt != 0);
    always @(posedge clk) begin
        if (rst)           tx_cnt <= 0;
        else if (tx_start) tx_cnt <= TXBUSY;
        else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [23:0] wr_q [$];
    int          wr_cyc [$];
    logic [7:0]  tx_q [$];
    int          tx_cyc [$];
    int          sel_on_wr = 0;
    int          pstart_cnt = 0;
    int          busy_on_start = 0;

    always @(negedge clk) begin
        if (ram_wr_en) begin
            wr_q.push_back({ram_addr, ram_wdata});
            wr_cyc.push_back(cyc);
            if (select) sel_on_wr++;
        end
        if (proc_start) pstart_cnt++;
        if (tx_start) begin
            tx_q.push_back(tx_data);
            tx_cyc.push_back(cyc);
            if (tx_busy) busy_on_start++;
        end
    end

    int          w_wr_cnt = 0;
    int          w_addr_err = 0;
    int          w_pstart_cnt = 0;
    logic [15:0] w_last_addr = 16'h0;
    logic [7:0]  w_last_data = 8'h0;
    always @(negedge clk) begin
        if (w_ram_wr_en) begin
            if (w_ram_addr !== 16'(w_wr_cnt)) w_addr_err++;
            w_last_addr = w_ram_addr;
            w_last_data = w_ram_wdata;
            w_wr_cnt++;
        end
        if (w_proc_start) w_pstart_cnt++;
    end

    logic [7:0] ld  [NLOAD];
    logic [7:0] res [NDUMP];

    // ---------------- stimulus helpers (entered at a negedge) ----------------
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; rx_valid = 1'b0; proc_done = 1'b0;
        @(negedge clk);
        wr_q.delete(); wr_cyc.delete(); tx_q.delete(); tx_cyc.delete();
        sel_on_wr = 0; pstart_cnt = 0; busy_on_start = 0;
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_sel(input logic v, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (select === v) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_tx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_q.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        checks++;
        if ({ram_wr_en, select, proc_start, tx_start, done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 00000", {ram_wr_en, select, proc_start, tx_start, done});
        end
        checks++;
        if (ram_addr !== 16'h0 || ram_wdata !== 8'h0 || tx_data !== 8'h0) begin
            errors++;
            $display("FAIL reset_data: got addr %h wdata %h txd %h expected all 0", ram_addr, ram_wdata, tx_data);
        end
    endtask

    task automatic test_load();
        bit ok;
        logic [23:0] exp;
        apply_reset();
        ld = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < NLOAD; i++) begin
            send_byte(ld[i]);
            repeat (2) @(negedge clk);
        end
        wait_sel(1'b1, 20, ok);
        @(negedge clk);
        checks++;
        if (!ok) begin errors++; $display("FAIL load_select: select got %b expected 1 within 20 cycles", select); end
        checks++;
        if (wr_q.size() != NLOAD) begin errors++; $display("FAIL load_count: got %0d writes expected %0d", wr_q.size(), NLOAD); end
        for (int i = 0; i < NLOAD && i < wr_q.size(); i++) begin
            exp = {16'(i), ld[i]};
            checks++;
            if (wr_q[i] !== exp) begin errors++; $display("FAIL load_write%0d: got %h expected %h", i, wr_q[i], exp); end
        end
        checks++;
        if (wr_cyc.size() == NLOAD && (wr_cyc[3] - wr_cyc[0]) != 9) begin
            errors++; $display("FAIL load_spacing: got %0d cycles expected 9", wr_cyc[3] - wr_cyc[0]);
        end
        checks++;
        if (sel_on_wr != 0) begin errors++; $display("FAIL load_sel_on_write: got %0d expected 0", sel_on_wr); end
        checks++;
        if (pstart_cnt != 1) begin errors++; $display("FAIL load_proc_start: got %0d pulses expected 1", pstart_cnt); end
    endtask

    task automatic test_proc_handoff();
        int sel_drop = 0;
        int n0;
        res = '{8'h5A, 8'h6B};
        for (int k = 0; k < NDUMP; k++) mem[BASE + 16'(k)] = res[k];
        n0 = wr_q.size();
        send_byte(8'hEE);
        repeat (50) begin
            @(negedge clk);
            if (select !== 1'b1) sel_drop++;
        end
        checks++;
        if (sel_drop != 0) begin errors++; $display("FAIL proc_select_held: got %0d low cycles expected 0", sel_drop); end
        checks++;
        if (tx_q.size() != 0) begin errors++; $display("FAIL proc_no_tx: got %0d tx_start expected 0", tx_q.size()); end
        checks++;
        if (wr_q.size() != n0) begin errors++; $display("FAIL proc_rx_ignored: got %0d writes expected %0d", wr_q.size(), n0); end
        proc_done = 1'b1;
        @(negedge clk);
        proc_done = 1'b0;
        checks++;
        if (select !== 1'b0 || ram_addr !== BASE) begin
            errors++; $display("FAIL proc_release: got select %b addr %h expected 0 %h", select, ram_addr, BASE);
        end
    endtask

    task automatic test_dump();
        bit ok;
        int n0 = wr_q.size();
        wait_tx(1, 100, ok);
        send_byte(8'h77);
        wait_done(400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL dump_done: done got %b expected 1 within 400 cycles", done); end
        checks++;
        if (tx_q.size() != NDUMP) begin errors++; $display("FAIL dump_count: got %0d bytes expected %0d", tx_q.size(), NDUMP); end
        for (int k = 0; k < NDUMP && k < tx_q.size(); k++) begin
            checks++;
            if (tx_q[k] !== res[k]) begin errors++; $display("FAIL dump_byte%0d: got %h expected %h", k, tx_q[k], res[k]); end
        end
        checks++;
        if (busy_on_start != 0) begin errors++; $display("FAIL dump_start_while_busy: got %0d expected 0", busy_on_start); end
        checks++;
        if (tx_cyc.size() >= 2 && (tx_cyc[1] - tx_cyc[0]) <= TXBUSY) begin
            errors++; $display("FAIL dump_gap: got %0d cycles expected > %0d", tx_cyc[1] - tx_cyc[0], TXBUSY);
        end
        checks++;
        if (wr_q.size() != n0) begin errors++; $display("FAIL dump_rx_ignored: got %0d writes expected %0d", wr_q.size(), n0); end
        repeat (10) @(negedge clk);
        checks++;
        if (done !== 1'b1 || select !== 1'b0 || pstart_cnt != 1 || tx_q.size() != NDUMP) begin
            errors++; $display("FAIL dump_hold: got done %b select %b pstart %0d tx %0d expected 1 0 1 %0d",
                                done, select, pstart_cnt, tx_q.size(), NDUMP);
        end
    endtask

    task automatic test_back_to_back_reset();
        bit ok;
        logic [23:0] exp;
        int n0;
        apply_reset();
        for (int i = 0; i < NLOAD; i++) ld[i] = 8'($urandom);
        for (int i = 0; i < NLOAD; i++) begin
            rx_data = ld[i]; rx_valid = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (wr_q.size() != NLOAD) begin errors++; $display("FAIL b2b_count: got %0d writes expected %0d", wr_q.size(), NLOAD); end
        for (int i = 0; i < NLOAD && i < wr_q.size(); i++) begin
            exp = {16'(i), ld[i]};
            checks++;
            if (wr_q[i] !== exp || wr_cyc[i] != wr_cyc[0] + i) begin
                errors++; $display("FAIL b2b_write%0d: got %h at +%0d expected %h at +%0d", i, wr_q[i], wr_cyc[i] - wr_cyc[0], exp, i);
            end
        end
        for (int k = 0; k < NDUMP; k++) begin res[k] = 8'($urandom); mem[BASE + 16'(k)] = res[k]; end
        wait_sel(1'b1, 20, ok);
        proc_done = 1'b1;
        @(negedge clk);
        proc_done = 1'b0;
        wait_tx(1, 100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_first_tx: tx count got %0d expected 1 within 100 cycles", tx_q.size()); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({select, done, ram_wr_en, tx_start, proc_start} !== 5'b0 || ram_addr !== 16'h0) begin
            errors++; $display("FAIL midrst_outputs: got sel %b done %b wr %b txs %b ps %b addr %h expected all 0",
                                select, done, ram_wr_en, tx_start, proc_start, ram_addr);
        end
        n0 = wr_q.size();
        send_byte(8'h3C);
        @(negedge clk);
        checks++;
        if (wr_q.size() != n0 + 1 || wr_q[$] !== {16'h0000, 8'h3C}) begin
            errors++; $display("FAIL midrst_reload: got %0d new writes last %h expected 1 000003c", wr_q.size() - n0, wr_q[$]);
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [23:0] exp;
        int bad;
        for (int it = 0; it < 4; it++) begin
            apply_reset();
            for (int i = 0; i < NLOAD; i++) ld[i] = 8'($urandom);
            for (int k = 0; k < NDUMP; k++) res[k] = 8'($urandom);
            for (int i = 0; i < NLOAD; i++) begin
                rx_data = ld[i]; rx_valid = 1'b1;
                @(negedge clk);
                rx_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_sel(1'b1, 20, ok);
            for (int k = 0; k < NDUMP; k++) mem[BASE + 16'(k)] = res[k];
            repeat ($urandom_range(1, 20)) @(negedge clk);
            proc_done = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            proc_done = 1'b0;
            wait_done(400, ok);
            bad = 0;
            for (int i = 0; i < NLOAD; i++) begin
                exp = {16'(i), ld[i]};
                if (i >= wr_q.size() || wr_q[i] !== exp) bad++;
            end
            for (int k = 0; k < NDUMP; k++) if (k >= tx_q.size() || tx_q[k] !== res[k]) bad++;
            checks++;
            if (!ok || bad != 0 || wr_q.size() != NLOAD || tx_q.size() != NDUMP || pstart_cnt != 1) begin
                errors++; $display("FAIL random%0d: got done %b bad %0d wr %0d tx %0d ps %0d expected 1 0 %0d %0d 1",
                                    it, done, bad, wr_q.size(), tx_q.size(), pstart_cnt, NLOAD, NDUMP);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] b = 8'h00;
        @(negedge clk);
        w_rst = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            b = 8'($urandom);
            w_rx_data = b; w_rx_valid = 1'b1;
            @(negedge clk);
        end
        w_rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        w_rx_data = 8'h99; w_rx_valid = 1'b1;
        @(negedge clk);
        w_rx_valid = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (w_wr_cnt != 65536 || w_addr_err != 0) begin
            errors++; $display("FAIL wrap_count: got %0d writes %0d addr errors expected 65536 0", w_wr_cnt, w_addr_err);
        end
        checks++;
        if (w_last_addr !== 16'hFFFF || w_last_data !== b) begin
            errors++; $display("FAIL wrap_last: got %h/%h expected ffff/%h", w_last_addr, w_last_data, b);
        end
        checks++;
        if (w_pstart_cnt != 1 || w_select !== 1'b1) begin
            errors++; $display("FAIL wrap_proc_start: got %0d pulses select %b expected 1 1", w_pstart_cnt, w_select);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        test_reset();
        test_load();
        test_proc_handoff();
        test_dump();
        test_back_to_back_reset();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
